// File: rtl/p16_mod_sub_pipe_if.sv
// p16_mod_sub_pipe_if: operand/result handshake bundle for the modulo (2^WIDTH-1) subtractor.
// Signals: in_valid/in_ready/a/b (operand side), out_valid/out_ready/diff/diff_zero (result side).
// Modports: master drives operands and out_ready; slave is the subtractor itself.
interface p16_mod_sub_pipe_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             diff_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, diff_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, diff_zero
  );
endinterface

// File: rtl/p16_mod_sub_pipe.sv
// p16_mod_sub_pipe: pipelined modulo (2^WIDTH-1) subtractor, diff = a + ~b summed with an
// end-around (cyclic) parallel-prefix carry tree split across three register stages.
// Ports: clk; rst (synchronous, active-high); io = slave side of p16_mod_sub_pipe_if
//   (a/b/in_valid/out_ready in; in_ready/out_valid/diff/diff_zero out).
// Latency 3 cycles accept-to-out_valid, one result per cycle. Each stage loads when empty or
// when its contents move on, so a stalled output lets the pipe fill (3 in flight) before in_ready drops.
module p16_mod_sub_pipe #(
  parameter int WIDTH     = 16,
  parameter bit NORMALIZE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  p16_mod_sub_pipe_if.slave io
);
  localparam int L  = $clog2(WIDTH);
  // Prefix levels done in S2; the rest are done in S3.
  localparam int LH = (L + 1) / 2;

  // Cyclic rotate: result bit i takes v[(i - s) mod WIDTH], i.e. the carry from s places below.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int s);
    return (v << s) | (v >> (WIDTH - s));
  endfunction

  logic             s1_v, s2_v, s3_v;
  logic [WIDTH-1:0] s1_g, s1_p, s1_x;
  logic [WIDTH-1:0] s2_g, s2_p, s2_x;
  logic [WIDTH-1:0] diff_q;
  logic             zero_q;
  logic             ld1, ld2, ld3;

  // Load enables chain back from the output: a stage takes new data when it is empty or
  // when the stage after it is loading this cycle.
  assign ld3 = !s3_v || io.out_ready;
  assign ld2 = !s2_v || ld3;
  assign ld1 = !s1_v || ld2;

  assign io.in_ready  = ld1 && !rst;
  assign io.out_valid = s3_v;
  assign io.diff      = diff_q;
  assign io.diff_zero = zero_q;

  // S1 operands: subtraction as addition of the one's complement.
  logic [WIDTH-1:0] y;
  assign y = ~io.b;

  // S2: lower half of the cyclic prefix tree.
  logic [WIDTH-1:0] g_lo, p_lo;
  always_comb begin
    g_lo = s1_g;
    p_lo = s1_p;
    for (int k = 0; k < LH; k++) begin
      g_lo = g_lo | (p_lo & rotl(g_lo, 1 << k));
      p_lo = p_lo & rotl(p_lo, 1 << k);
    end
  end

  // S3: remaining prefix levels, then the carry into bit i is the group generate of bit i-1
  // wrapping around, which is what makes the sum end-around.
  logic [WIDTH-1:0] g_hi, p_hi, sum, diff_nxt;
  logic             zero_nxt;
  always_comb begin
    g_hi = s2_g;
    p_hi = s2_p;
    for (int k = LH; k < L; k++) begin
      g_hi = g_hi | (p_hi & rotl(g_hi, 1 << k));
      p_hi = p_hi & rotl(p_hi, 1 << k);
    end
    sum = s2_x ^ rotl(g_hi, 1);
    // All-ones is the second encoding of zero (a == b gives it).
    if (NORMALIZE && (&sum)) diff_nxt = '0;
    else                     diff_nxt = sum;
    zero_nxt = (diff_nxt == '0) || (&diff_nxt);
  end

  // Valid bits and the output registers are the only reset state.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s3_v   <= 1'b0;
      diff_q <= '0;
      zero_q <= 1'b0;
    end else begin
      if (ld1) s1_v <= io.in_valid;
      if (ld2) s2_v <= s1_v;
      if (ld3) begin
        s3_v <= s2_v;
        if (s2_v) begin
          diff_q <= diff_nxt;
          zero_q <= zero_nxt;
        end
      end
    end
  end

  // Datapath registers: contents are only meaningful under their stage's valid bit.
  always_ff @(posedge clk) begin
    if (ld1) begin
      s1_g <= io.a & y;
      s1_p <= io.a | y;
      s1_x <= io.a ^ y;
    end
    if (ld2) begin
      s2_g <= g_lo;
      s2_p <= p_lo;
      s2_x <= s1_x;
    end
  end
endmodule

// File: tb/tb_p16_mod_sub_pipe.sv
// tb_p16_mod_sub_pipe: self-checking bench for the modulo (2^16-1) subtractor pipeline.
// Drives one NORMALIZE=1 instance through directed, streaming, stall, reset and random traffic
// checked against an arithmetic mod-65535 model, plus a NORMALIZE=0 instance for zero encodings.
module tb_p16_mod_sub_pipe;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  p16_mod_sub_pipe_if #(.WIDTH(W)) io ();
  p16_mod_sub_pipe_if #(.WIDTH(W)) io_nn ();

  p16_mod_sub_pipe #(.WIDTH(W), .NORMALIZE(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  p16_mod_sub_pipe #(.WIDTH(W), .NORMALIZE(1'b0)) u_dut_nn (
    .clk (clk),
    .rst (rst),
    .io  (io_nn.slave)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [W-1:0] exp_q[$];

  // Residue arithmetic: both 0 and 0xFFFF mean zero; result in canonical form 0..65534.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned m, av, bv;
    m  = 65535;
    av = int'(a) % m;
    bv = int'(b) % m;
    return 16'((av + m - bv) % m);
  endfunction

  // Operand generator biased toward the zero encodings.
  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // One clock of stimulus; reports the handshakes that the next edge will perform.
  task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ordy, output logic acc, output logic emit,
                       output logic [W-1:0] d, output logic dz);
    @(posedge clk); #1;
    io.in_valid  = iv;
    io.a         = ia;
    io.b         = ib;
    io.out_ready = ordy;
    #1;
    acc  = iv && io.in_ready;
    emit = io.out_valid && ordy;
    d    = io.diff;
    dz   = io.diff_zero;
    if (acc) exp_q.push_back(model(ia, ib));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io.in_valid = 1'b0; io.a = '0; io.b = '0; io.out_ready = 1'b1;
    io_nn.in_valid = 1'b0; io_nn.a = '0; io_nn.b = '0; io_nn.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (io.out_valid !== 1'b0 || io.diff !== 16'h0000 || io.diff_zero !== 1'b0)
      $display("FAIL reset_outputs: out_valid=%b diff=%h diff_zero=%b, want 0/0000/0",
               io.out_valid, io.diff, io.diff_zero);
    else pass_cnt++;
    total_cnt++;
    if (io.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", io.in_ready);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (io.in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b want 1", io.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[6] = '{16'h0005, 16'h0003, 16'h1234, 16'hFFFF, 16'h0000, 16'h8000};
    logic [W-1:0] tb[6] = '{16'h0003, 16'h0005, 16'h1234, 16'h0000, 16'hFFFF, 16'hFFFF};
    logic [W-1:0] te[6] = '{16'h0002, 16'hFFFD, 16'h0000, 16'h0000, 16'h0000, 16'h8000};
    logic acc, emit, dz, got;
    logic [W-1:0] d, gd;
    logic gz;
    int lat;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, ta[i], tb[i], 1'b1, acc, emit, d, dz);
      total_cnt++;
      if (acc !== 1'b1) $display("FAIL directed_accept[%0d]: accepted=%b want 1", i, acc);
      else pass_cnt++;
      got = 1'b0; lat = 0; gd = '0; gz = 1'b0;
      for (int n = 1; n <= 10 && !got; n++) begin
        cycle(1'b0, '0, '0, 1'b1, acc, emit, d, dz);
        if (emit) begin got = 1'b1; lat = n; gd = d; gz = dz; end
      end
      total_cnt++;
      if (!got || lat != 3) $display("FAIL directed_latency[%0d]: got=%b cycles=%0d want 3", i, got, lat);
      else pass_cnt++;
      total_cnt++;
      if (gd !== te[i] || gz !== (te[i] == 16'h0000))
        $display("FAIL directed_value[%0d] a=%h b=%h: diff=%h zero=%b want %h/%b",
                 i, ta[i], tb[i], gd, gz, te[i], te[i] == 16'h0000);
      else pass_cnt++;
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic acc, emit, dz;
    logic [W-1:0] d, e;
    int first, last, n_out, n_acc;
    first = -1; last = -1; n_out = 0; n_acc = 0;
    for (int c = 0; c < 40; c++) begin
      cycle(c < 20, rand_op(), rand_op(), 1'b1, acc, emit, d, dz);
      if (acc) n_acc++;
      if (emit) begin
        if (first < 0) first = c;
        last = c;
        n_out++;
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL b2b_extra: unexpected diff=%h", d);
        else begin
          e = exp_q.pop_front();
          if (d !== e || dz !== (e == 16'h0000))
            $display("FAIL b2b_value: diff=%h zero=%b want %h/%b", d, dz, e, e == 16'h0000);
          else pass_cnt++;
        end
      end
    end
    total_cnt++;
    if (n_acc != 20) $display("FAIL b2b_in_ready: accepts=%0d want 20", n_acc);
    else pass_cnt++;
    total_cnt++;
    if (n_out != 20 || last - first != 19)
      $display("FAIL b2b_rate: results=%0d span=%0d want 20/19", n_out, last - first);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    logic acc, emit, dz, have, seen;
    logic [W-1:0] d, e, pa, pb, held;
    int n_acc, n_out, bad;
    n_acc = 0; n_out = 0; bad = 0; have = 1'b0; seen = 1'b0; held = '0; pa = '0; pb = '0;
    for (int c = 0; c < 6; c++) begin
      if (!have) begin pa = rand_op(); pb = rand_op(); have = 1'b1; end
      cycle(1'b1, pa, pb, 1'b0, acc, emit, d, dz);
      if (acc) begin n_acc++; have = 1'b0; end
      if (io.out_valid) begin
        if (!seen) begin held = d; seen = 1'b1; end
        else if (d !== held) bad++;
      end
    end
    total_cnt++;
    if (n_acc != 3) $display("FAIL stall_accepts: accepts=%0d want 3", n_acc);
    else pass_cnt++;
    total_cnt++;
    if (!seen || bad != 0) $display("FAIL stall_hold: out_valid_seen=%b changes=%0d want 1/0", seen, bad);
    else pass_cnt++;
    for (int c = 0; c < 20; c++) begin
      if (!have && c < 5) begin pa = rand_op(); pb = rand_op(); have = 1'b1; end
      cycle(have, pa, pb, 1'b1, acc, emit, d, dz);
      if (acc) have = 1'b0;
      if (emit) begin
        n_out++;
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL stall_extra: unexpected diff=%h", d);
        else begin
          e = exp_q.pop_front();
          if (d !== e || dz !== (e == 16'h0000))
            $display("FAIL stall_value: diff=%h zero=%b want %h/%b", d, dz, e, e == 16'h0000);
          else pass_cnt++;
        end
      end
    end
    total_cnt++;
    if (n_out != 8 || exp_q.size() != 0)
      $display("FAIL stall_drain: results=%0d left=%0d want 8/0", n_out, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic acc, emit, dz, got;
    logic [W-1:0] d, gd;
    int stale;
    cycle(1'b1, 16'h4444, 16'h1111, 1'b1, acc, emit, d, dz);
    cycle(1'b1, 16'h5555, 16'h2222, 1'b1, acc, emit, d, dz);
    @(posedge clk); #1;
    rst = 1'b1;
    io.in_valid = 1'b0;
    #1;
    total_cnt++;
    if (io.in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b want 0", io.in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    total_cnt++;
    if (io.out_valid !== 1'b0 || io.diff !== 16'h0000 || io.diff_zero !== 1'b0 || io.in_ready !== 1'b1)
      $display("FAIL midrst_state: out_valid=%b diff=%h zero=%b in_ready=%b want 0/0000/0/1",
               io.out_valid, io.diff, io.diff_zero, io.in_ready);
    else pass_cnt++;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, '0, '0, 1'b1, acc, emit, d, dz);
      if (emit) stale++;
    end
    total_cnt++;
    if (stale != 0) $display("FAIL midrst_stale: results=%0d want 0", stale);
    else pass_cnt++;
    cycle(1'b1, 16'h0007, 16'h0009, 1'b1, acc, emit, d, dz);
    got = 1'b0; gd = '0;
    for (int n = 0; n < 10 && !got; n++) begin
      cycle(1'b0, '0, '0, 1'b1, acc, emit, d, dz);
      if (emit) begin got = 1'b1; gd = d; end
    end
    exp_q.delete();
    total_cnt++;
    if (!got || gd !== 16'hFFFD) $display("FAIL midrst_after: got=%b diff=%h want 1/fffd", got, gd);
    else pass_cnt++;
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic acc, emit, dz, have, iv;
    logic [W-1:0] d, e, pa, pb;
    int sent, cyc;
    sent = 0; cyc = 0; have = 1'b0; pa = '0; pb = '0;
    while ((sent < N || exp_q.size() != 0) && cyc < 60000) begin
      if (!have && sent < N) begin
        pa = rand_op();
        pb = ($urandom_range(0, 7) == 0) ? pa : rand_op();
        have = 1'b1;
      end
      iv = have && ($urandom_range(0, 3) != 0);
      cycle(iv, pa, pb, $urandom_range(0, 2) != 0, acc, emit, d, dz);
      if (acc) begin have = 1'b0; sent++; end
      if (emit) begin
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL random_extra: unexpected diff=%h", d);
        else begin
          e = exp_q.pop_front();
          if (d !== e || dz !== (e == 16'h0000))
            $display("FAIL random_value: diff=%h zero=%b want %h/%b", d, dz, e, e == 16'h0000);
          else pass_cnt++;
        end
      end
      cyc++;
    end
    total_cnt++;
    if (sent != N || exp_q.size() != 0)
      $display("FAIL random_complete: sent=%0d pending=%0d want %0d/0", sent, exp_q.size(), N);
    else pass_cnt++;
  endtask

  task automatic test_no_normalize();
    logic [W-1:0] va[5], vb[5], ve[5], r, gd;
    logic vz[5];
    logic got, gz;
    r = 16'($urandom);
    va = '{16'h1234, r,        16'h0005, 16'h0000, 16'hFFFF};
    vb = '{16'h1234, r,        16'h0003, 16'hFFFF, 16'h0000};
    ve = '{16'hFFFF, 16'hFFFF, 16'h0002, 16'h0000, 16'hFFFF};
    vz = '{1'b1,     1'b1,     1'b0,     1'b1,     1'b1};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      io_nn.in_valid = 1'b1; io_nn.a = va[i]; io_nn.b = vb[i]; io_nn.out_ready = 1'b1;
      @(posedge clk); #1;
      io_nn.in_valid = 1'b0;
      got = 1'b0; gd = '0; gz = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
        if (io_nn.out_valid) begin got = 1'b1; gd = io_nn.diff; gz = io_nn.diff_zero; end
        else begin @(posedge clk); #1; end
      end
      total_cnt++;
      if (!got || gd !== ve[i] || gz !== vz[i])
        $display("FAIL nonorm[%0d] a=%h b=%h: got=%b diff=%h zero=%b want %h/%b",
                 i, va[i], vb[i], got, gd, gz, ve[i], vz[i]);
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    test_no_normalize();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
